i2c_master_arbiter: RTL and testbench

Shares one `i2c_master` instance between `NREQ` independent requesters (temperature sensor poller, EEPROM reader, etc.). It sits between the requester-side job logic and the `i2c_master` command/data ports. It grants the bus round-robin, launches the winner's transfer with a one-cycle start strobe, and routes the data handshakes to the current owner only. It reports per-requester completion or failure.

---
 rtl/i2c_master_arbiter.sv | 166 ++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NREQ requesters.
// Define I2C_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration.
module i2c_master_arbiter #(
  parameter int NREQ          = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_nbytes,
  input  logic [NREQ*7-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*8-1:0] req_write_data,
  output logic [NREQ-1:0]   req_tx_data_req,
  output logic [NREQ-1:0]   req_rx_data_ready,
  output logic [7:0]        rx_data,
  output logic [NREQ-1:0]   req_done,
  output logic [NREQ-1:0]   req_failed,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              m_start,
  output logic [7:0]        m_nbytes,
  output logic [6:0]        m_addr,
  output logic              m_rw_mode,
  output logic [7:0]        m_write_data,
  input  logic [7:0]        m_read_data,
  input  logic              m_tx_data_req,
  input  logic              m_rx_data_ready,
  input  logic              m_idle,
  input  logic              m_tranfer_failed
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] START    = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] RUN      = 2'd3;

  localparam logic I2C_MODE_WRITE = 1'b0;

  localparam int CW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 2);

  logic [1:0]      state;
  logic [2:0]      grant;
  logic            fail;
  logic [CW-1:0]   cnt;
  logic [2:0]      win;
  logic [NREQ-1:0] grant_oh;
  logic            active;
  logic [7:0]      sel_nbytes;
  logic [6:0]      sel_addr;
  logic            sel_rw;

`ifdef I2C_ARB_FIXED_PRIORITY_EN
  always_comb begin
    win = '0;
    for (int unsigned i = NREQ; i > 0; i--)
      if (req_valid[i-1]) win = 3'(i - 1);
  end
`else
  logic [2:0]      last_grant;
  logic [NREQ-1:0] rot;
  logic [3:0]      ofs;
  logic [3:0]      sum;

  // Rotate so bit 0 is last_grant+1; the lowest set bit is then the winner.
  always_comb begin
    rot = NREQ'({req_valid, req_valid} >> (4'(last_grant) + 4'd1));
    ofs = '0;
    for (int unsigned i = NREQ; i > 0; i--)
      if (rot[i-1]) ofs = 4'(i - 1);
    sum = 4'(last_grant) + 4'd1 + ofs;
    if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
    win = sum[2:0];
  end
`endif

  always_comb begin
    active   = (state != IDLE);
    busy     = active;
    m_start  = (state == START);
    grant_id = grant;
    rx_data  = m_read_data;
    grant_oh = NREQ'(1) << grant;
    req_ready         = m_start ? grant_oh : '0;
    req_tx_data_req   = (active && m_tx_data_req) ? grant_oh : '0;
    req_rx_data_ready = (active && m_rx_data_ready) ? grant_oh : '0;
  end

  always_comb begin
    sel_nbytes   = '0;
    sel_addr     = '0;
    sel_rw       = I2C_MODE_WRITE;
    m_write_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == 3'(i)) begin
        sel_nbytes = req_nbytes[i*8 +: 8];
        sel_addr   = req_addr[i*7 +: 7];
        sel_rw     = req_rw[i];
      end
      if (active && grant == 3'(i)) m_write_data = req_write_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      fail       <= 1'b0;
      cnt        <= '0;
      m_nbytes   <= '0;
      m_addr     <= '0;
      m_rw_mode  <= I2C_MODE_WRITE;
      req_done   <= '0;
      req_failed <= '0;
`ifndef I2C_ARB_FIXED_PRIORITY_EN
      last_grant <= 3'(NREQ - 1);
`endif
    end else begin
      req_done   <= '0;
      req_failed <= '0;
      case (state)
        IDLE: begin
          if (m_idle && |req_valid) begin
            grant     <= win;
`ifndef I2C_ARB_FIXED_PRIORITY_EN
            last_grant <= win;
`endif
            m_nbytes  <= sel_nbytes;
            m_addr    <= sel_addr;
            m_rw_mode <= sel_rw;
            state     <= START;
          end
        end
        START: begin
          fail  <= 1'b0;
          cnt   <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (m_tranfer_failed) fail <= 1'b1;
          if (!m_idle) begin
            state <= RUN;
          end else if (cnt == TO_LAST) begin
            state      <= IDLE;
            req_failed <= grant_oh;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (m_idle) begin
            state <= IDLE;
            if (fail || m_tranfer_failed) req_failed <= grant_oh;
            else                          req_done   <= grant_oh;
          end else if (m_tranfer_failed) begin
            fail <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: directed scenarios plus randomized traffic
// against a transfer-level model, with a simple i2c_master behavioural model.
module tb_i2c_master_arbiter;
  localparam int NREQ = 2;
  localparam int T    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_rw;
  logic [NREQ*8-1:0] req_nbytes, req_write_data;
  logic [NREQ*7-1:0] req_addr;
  logic [NREQ-1:0]   req_tx_data_req, req_rx_data_ready, req_done, req_failed;
  logic [7:0]        rx_data, m_nbytes, m_write_data, m_read_data;
  logic [6:0]        m_addr;
  logic [2:0]        grant_id;
  logic              busy, m_start, m_rw_mode;
  logic              m_tx_data_req, m_rx_data_ready, m_idle, m_tranfer_failed;

  i2c_master_arbiter #(.NREQ(NREQ), .START_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_nbytes(req_nbytes),
    .req_addr(req_addr), .req_rw(req_rw), .req_write_data(req_write_data),
    .req_tx_data_req(req_tx_data_req), .req_rx_data_ready(req_rx_data_ready),
    .rx_data(rx_data), .req_done(req_done), .req_failed(req_failed),
    .grant_id(grant_id), .busy(busy), .m_start(m_start), .m_nbytes(m_nbytes),
    .m_addr(m_addr), .m_rw_mode(m_rw_mode), .m_write_data(m_write_data),
    .m_read_data(m_read_data), .m_tx_data_req(m_tx_data_req),
    .m_rx_data_ready(m_rx_data_ready), .m_idle(m_idle),
    .m_tranfer_failed(m_tranfer_failed)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  bit rand_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer-level reference model: who owns the master and how its job ends.
  bit              md_active = 1'b0, md_in_start = 1'b0, md_was_start, md_acked, md_fail;
  int              md_owner = 0, md_last = NREQ - 1, md_since;
  logic [NREQ-1:0] e_done = '0, e_failed = '0;
  logic [7:0]      e_nb = '0;
  logic [6:0]      e_addr = '0;
  logic            e_rw = 1'b0;

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef I2C_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return 0;
  endfunction

  task automatic end_xfer(input bit f);
    md_active = 1'b0;
    if (f) e_failed[md_owner] = 1'b1;
    else   e_done[md_owner]   = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      md_active = 1'b0; md_in_start = 1'b0; md_last = NREQ - 1; md_owner = 0;
      e_done = '0; e_failed = '0; e_nb = '0; e_addr = '0; e_rw = 1'b0;
    end else begin
      e_done = '0; e_failed = '0;
      md_was_start = md_in_start;
      md_in_start = 1'b0;
      if (!md_active) begin
        if (m_idle && |req_valid) begin
          md_owner = pick(req_valid, md_last);
          md_last = md_owner;
          md_active = 1'b1; md_in_start = 1'b1;
          md_fail = 1'b0; md_acked = 1'b0; md_since = 0;
          e_nb = req_nbytes[md_owner*8 +: 8];
          e_addr = req_addr[md_owner*7 +: 7];
          e_rw = req_rw[md_owner];
        end
      end else if (!md_was_start) begin
        if (m_tranfer_failed) md_fail = 1'b1;
        if (!md_acked) begin
          if (!m_idle) md_acked = 1'b1;
          else begin
            md_since++;
            if (md_since == T - 1) end_xfer(1'b1);
          end
        end else if (m_idle) end_xfer(md_fail);
      end
    end
  end

  logic [NREQ-1:0] exp_oh;
  always @(negedge clk) if (cmp_en) begin
    exp_oh = md_active ? (NREQ'(1) << md_owner) : {NREQ{1'b0}};
    chk("m_start", m_start, md_in_start);
    chk("req_ready", req_ready, md_in_start ? exp_oh : {NREQ{1'b0}});
    chk("busy", busy, md_active);
    chk("grant_id", grant_id, md_owner);
    chk("req_done", req_done, e_done);
    chk("req_failed", req_failed, e_failed);
    chk("m_nbytes", m_nbytes, e_nb);
    chk("m_addr", m_addr, e_addr);
    chk("m_rw_mode", m_rw_mode, e_rw);
    chk("req_tx_data_req", req_tx_data_req, m_tx_data_req ? exp_oh : {NREQ{1'b0}});
    chk("req_rx_data_ready", req_rx_data_ready, m_rx_data_ready ? exp_oh : {NREQ{1'b0}});
    chk("m_write_data", m_write_data, md_active ? req_write_data[md_owner*8 +: 8] : 8'h00);
    chk("rx_data", rx_data, m_read_data);
  end

  // i2c_master behavioural model.
  bit        dir_ign = 1'b0, dir_fail = 1'b0, dir_fe = 1'b0;
  int        dir_dly = 1;
  logic [7:0] dir_rbase = 8'h00;
  int        ms_nb, ms_dly;
  bit        ms_rd, ms_ign, ms_fl, ms_fe;
  logic [7:0] ms_rb;

  initial begin
    m_idle = 1'b1; m_tx_data_req = 1'b0; m_rx_data_ready = 1'b0;
    m_tranfer_failed = 1'b0; m_read_data = 8'h00;
    forever begin
      @(negedge clk);
      if (m_start === 1'b1) begin
        ms_nb = int'(m_nbytes); ms_rd = m_rw_mode;
        if (rand_en) begin
          ms_ign = ($urandom % 10 == 0); ms_fl = ($urandom % 5 == 0);
          ms_fe = ($urandom % 10 == 0); ms_rb = 8'($urandom);
          ms_dly = ($urandom % 4 == 0) ? int'($urandom_range(1, T + 1)) : int'($urandom_range(1, 3));
        end else begin
          ms_ign = dir_ign; ms_fl = dir_fail; ms_fe = dir_fe;
          ms_rb = dir_rbase; ms_dly = dir_dly;
        end
        @(posedge clk);
        if (!ms_ign) begin
          repeat (ms_dly - 1) @(posedge clk);
          #1 m_idle = 1'b0;
          for (int b = 0; b < ms_nb; b++) begin
            @(posedge clk); #1;
            m_tranfer_failed = 1'b0;
            if (ms_rd) begin m_read_data = ms_rb + 8'(b); m_rx_data_ready = 1'b1; end
            else m_tx_data_req = 1'b1;
            @(posedge clk); #1;
            m_rx_data_ready = 1'b0; m_tx_data_req = 1'b0;
            if (ms_fl && b == ms_nb / 2) m_tranfer_failed = 1'b1;
          end
          @(posedge clk); #1;
          m_tranfer_failed = ms_fe; m_idle = 1'b1;
          @(posedge clk); #1;
          m_tranfer_failed = 1'b0;
        end
      end
    end
  end

  // Directed helpers.
  int              w_tx[NREQ], w_rx[NREQ];
  logic [7:0]      w_rxq[$];
  logic [NREQ-1:0] w_done, w_fail, rdy_s;
  int              w_grant, w_startcyc, w_endcyc, early;
  bit              got;
  int              exp_g[4];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input int nb, input int ad, input bit rw);
    req_nbytes[i*8 +: 8] = 8'(nb);
    req_addr[i*7 +: 7] = 7'(ad);
    req_rw[i] = rw;
  endtask

  task automatic do_reset();
    req_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_xfer(input bit hold);
    for (int i = 0; i < NREQ; i++) begin w_tx[i] = 0; w_rx[i] = 0; end
    w_rxq.delete(); w_done = '0; w_fail = '0; w_grant = -1; w_startcyc = -1; got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (req_tx_data_req[i]) w_tx[i]++;
        if (req_rx_data_ready[i]) begin w_rx[i]++; w_rxq.push_back(rx_data); end
      end
      if (m_start) begin w_grant = int'(grant_id); w_startcyc = cyc; end
      if (!hold) req_valid = req_valid & ~req_ready;
      if (|req_done || |req_failed) begin
        got = 1'b1; w_done = req_done; w_fail = req_failed; w_endcyc = cyc;
      end
    end
    chk("xfer_end_seen", got, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_nbytes = '0; req_addr = '0; req_rw = '0;
    req_write_data = 16'hA55A;
    @(posedge clk); #1 cmp_en = 1'b1;
    tick();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_m_start", m_start, 0);
    chk("rst_grant", grant_id, 0); chk("rst_done", req_done, 0);
    chk("rst_rw", m_rw_mode, 0); chk("rst_ready", req_ready, 0);
    tick();

    // Single write request.
    dir_dly = 1;
    set_req(0, 2, 'h45, 1'b0);
    req_valid = 2'b01;
    @(negedge clk);
    chk("single_no_early_start", m_start, 0);
    @(negedge clk);
    chk("single_start", m_start, 1); chk("single_addr", m_addr, 'h45);
    chk("single_nbytes", m_nbytes, 2); chk("single_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    wait_xfer(1'b1);
    chk("single_tx0", w_tx[0], 2); chk("single_tx1", w_tx[1], 0);
    chk("single_done", w_done, 2'b01); chk("single_fail", w_fail, 0);
    tick();

    // Contention, both held valid.
`ifdef I2C_ARB_FIXED_PRIORITY_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    do_reset();
    set_req(0, 1, 'h10, 1'b0); set_req(1, 1, 'h20, 1'b0);
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_xfer(1'b1);
      chk("contend_grant", w_grant, exp_g[n]);
    end
    req_valid = '0;
    tick();

    // Read routing to requester 1.
    do_reset();
    dir_rbase = 8'h11;
    set_req(1, 6, 'h33, 1'b1);
    req_valid = 2'b10;
    wait_xfer(1'b0);
    chk("read_rx1", w_rx[1], 6); chk("read_rx0", w_rx[0], 0);
    chk("read_done", w_done, 2'b10);
    chk("read_nbytes_seen", w_rxq.size(), 6);
    foreach (w_rxq[k]) chk("read_byte", w_rxq[k], 8'h11 + 8'(k));
    tick();

    // Mid-run failure, then a normal request.
    do_reset();
    dir_fail = 1'b1;
    set_req(0, 4, 'h50, 1'b0);
    req_valid = 2'b01;
    wait_xfer(1'b0);
    chk("fail_failed", w_fail, 2'b01); chk("fail_done", w_done, 0);
    dir_fail = 1'b0;
    tick();
    set_req(1, 2, 'h51, 1'b0);
    req_valid = 2'b10;
    wait_xfer(1'b0);
    chk("after_fail_grant", w_grant, 1); chk("after_fail_done", w_done, 2'b10);
    tick();

    // Start timeout.
    do_reset();
    dir_ign = 1'b1;
    set_req(0, 3, 'h60, 1'b0);
    req_valid = 2'b01;
    wait_xfer(1'b0);
    chk("timeout_failed", w_fail, 2'b01);
    chk("timeout_latency", w_endcyc - w_startcyc, T);
    chk("timeout_busy", busy, 0);
    dir_ign = 1'b0;
    tick();

    // Reset while the master is running.
    do_reset();
    set_req(0, 4, 'h22, 1'b0);
    req_valid = 2'b01;
    for (int n = 0; n < 50 && m_idle; n++) tick();
    req_valid = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstrun_busy", busy, 0); chk("rstrun_start", m_start, 0);
    chk("rstrun_grant", grant_id, 0); chk("rstrun_addr", m_addr, 0);
    chk("rstrun_nbytes", m_nbytes, 0); chk("rstrun_master_busy", m_idle, 0);
    req_valid = 2'b11;
    early = 0;
    for (int n = 0; n < 100; n++) begin
      if (m_start) early++;
      if (m_idle) break;
      @(negedge clk);
    end
    chk("rstrun_no_grant", early, 0);
    wait_xfer(1'b0);
    chk("rstrun_first_grant", w_grant, 0);
    req_valid = '0;
    tick();

    // Randomized traffic.
    rand_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rdy_s = req_ready;
      tick();
      rst = ($urandom % 500 == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (rdy_s[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom % 3 == 0) begin
          set_req(i, int'($urandom_range(1, 4)), int'($urandom % 128), 1'($urandom % 2));
          req_valid[i] = 1'b1;
        end
      end
      req_write_data = NREQ*8'($urandom);
    end
    rst = 1'b0; rand_en = 1'b0; req_valid = '0;
    repeat (80) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
